// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the single-clock programmable FIFO.
package sync_fifo_pkg;

  // Read-mode selector, carried as a 5-character ASCII string ("TRUE"/"FALSE").
  typedef logic [39:0] mode_str_t;

  localparam mode_str_t MODE_TRUE  = {8'h00, "TRUE"};
  localparam mode_str_t MODE_FALSE = "FALSE";

  // Number of entries for a given address width; never returns less than 2.
  function automatic int depth_of(input int asize);
    return (asize < 1) ? 2 : (1 << asize);
  endfunction

  // True when the mode string selects first-word fall-through.
  function automatic bit is_fwft(input mode_str_t mode);
    return mode == MODE_TRUE;
  endfunction

  // Status bundle, laid out for CSR readback.
  typedef struct packed {
    logic wfull;
    logic awfull;
    logic rempty;
    logic arempty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for the FIFO: one write port, one read port.
// FWFT = 1 gives an asynchronous read port; FWFT = 0 gives a registered one.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DSIZE = 16,
  parameter int ASIZE = 4,
  parameter bit FWFT  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic             re,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  localparam int DEPTH = depth_of(ASIZE);

  logic [DSIZE-1:0] mem [DEPTH];
  logic [DSIZE-1:0] rd_q;

  // Write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port: loads only on an accepted pop, holds otherwise.
  always_ff @(posedge clk) begin
    if (rst)     rd_q <= '0;
    else if (re) rd_q <= mem[raddr];
  end

  // The unused path is trimmed by synthesis for a fixed FWFT value.
  assign rdata = FWFT ? mem[raddr] : rd_q;

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// exact occupancy, synchronous flush and sticky overflow/underflow flags.
//
// Handshake: winc/rinc are requests; ready for them is ~wfull / ~rempty taken
// from the registered level. A request is accepted (wr_ok / rd_ok) only on an
// edge where its ready is high and flush is low; a same-cycle pop never frees
// a slot for a same-cycle write. A request made while not ready is dropped and
// raises the matching sticky error flag (unless flush is high).
module sync_fifo_prog
  import sync_fifo_pkg::*;
#(
  parameter int        DSIZE       = 16,
  parameter int        ASIZE       = 4,
  parameter mode_str_t FALLTHROUGH = MODE_TRUE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             clear_err,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  output logic             awfull,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             arempty,
  input  logic [ASIZE:0]   af_thresh,
  input  logic [ASIZE:0]   ae_thresh,
  output logic [ASIZE:0]   level,
  output logic             overflow,
  output logic             underflow
);

  localparam bit           FWFT    = is_fwft(FALLTHROUGH);
  localparam logic [ASIZE:0] DEPTH_L = {1'b1, {ASIZE{1'b0}}};

  logic [ASIZE:0]   level_q;
  logic [ASIZE-1:0] waddr_q;
  logic [ASIZE-1:0] raddr_q;
  logic             overflow_q;
  logic             underflow_q;
  logic             wr_ok;
  logic             rd_ok;
  fifo_status_t     status;

  // All flags are plain compares on the level register, so thresholds take
  // effect in the same cycle they change.
  always_comb begin
    status           = '0;
    status.wfull     = (level_q == DEPTH_L);
    status.rempty    = (level_q == '0);
    status.awfull    = (level_q >= af_thresh);
    status.arempty   = (level_q <= ae_thresh);
    status.overflow  = overflow_q;
    status.underflow = underflow_q;
  end

  assign wr_ok = winc & ~status.wfull  & ~flush;
  assign rd_ok = rinc & ~status.rempty & ~flush;

  // Pointer and occupancy update; flush behaves like a contents-only reset.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      waddr_q <= '0;
      raddr_q <= '0;
      level_q <= '0;
    end else begin
      if (wr_ok) waddr_q <= waddr_q + ASIZE'(1);
      if (rd_ok) raddr_q <= raddr_q + ASIZE'(1);
      case ({wr_ok, rd_ok})
        2'b10:   level_q <= level_q + (ASIZE+1)'(1);
        2'b01:   level_q <= level_q - (ASIZE+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Sticky error flags; clear_err wins over a same-cycle set and flush
  // suppresses new sets because it also cancels the requests.
  always_ff @(posedge clk) begin
    if (rst || clear_err) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (winc && status.wfull  && !flush) overflow_q  <= 1'b1;
      if (rinc && status.rempty && !flush) underflow_q <= 1'b1;
    end
  end

  sync_fifo_mem #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE),
    .FWFT  (FWFT)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .waddr (waddr_q),
    .wdata (wdata),
    .re    (rd_ok),
    .raddr (raddr_q),
    .rdata (rdata)
  );

  assign wfull     = status.wfull;
  assign awfull    = status.awfull;
  assign rempty    = status.rempty;
  assign arempty   = status.arempty;
  assign overflow  = status.overflow;
  assign underflow = status.underflow;
  assign level     = level_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench for sync_fifo_prog: one FWFT instance and one registered-read
// instance driven by the same inputs, DSIZE = 8, ASIZE = 2 (DEPTH = 4).
module tb_sync_fifo_prog;

  localparam int DSIZE = 8;
  localparam int ASIZE = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, flush, clear_err, winc, rinc;
  logic [DSIZE-1:0] wdata;
  logic [ASIZE:0]   af_thresh, ae_thresh;

  logic             wfull, awfull, rempty, arempty, overflow, underflow;
  logic [DSIZE-1:0] rdata;
  logic [ASIZE:0]   level;

  logic             wfull_r, awfull_r, rempty_r, arempty_r, overflow_r, underflow_r;
  logic [DSIZE-1:0] rdata_r;
  logic [ASIZE:0]   level_r;

  sync_fifo_prog #(.DSIZE(DSIZE), .ASIZE(ASIZE), .FALLTHROUGH("TRUE")) dut (
    .clk(clk), .rst(rst), .flush(flush), .clear_err(clear_err),
    .winc(winc), .wdata(wdata), .wfull(wfull), .awfull(awfull),
    .rinc(rinc), .rdata(rdata), .rempty(rempty), .arempty(arempty),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh), .level(level),
    .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_prog #(.DSIZE(DSIZE), .ASIZE(ASIZE), .FALLTHROUGH("FALSE")) dut_reg (
    .clk(clk), .rst(rst), .flush(flush), .clear_err(clear_err),
    .winc(winc), .wdata(wdata), .wfull(wfull_r), .awfull(awfull_r),
    .rinc(rinc), .rdata(rdata_r), .rempty(rempty_r), .arempty(arempty_r),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh), .level(level_r),
    .overflow(overflow_r), .underflow(underflow_r)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic           w;
    logic [7:0]     wd;
    logic           r;
    logic           fl;
    logic           ce;
    logic [2:0]     af;
    logic [2:0]     ae;
    logic [2:0]     lvl;
    logic           full;
    logic           empty;
    logic           awf;
    logic           are;
    logic           ovf;
    logic           udf;
    logic [7:0]     fw;   // FWFT rdata, checked only when not empty
    logic [7:0]     rg;   // registered-read rdata
  } vec_t;

  vec_t vecs[$];

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- scoreboard ----------------
  logic [DSIZE-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic w, input logic [7:0] wd, input logic r,
                         input logic fl, input logic ce, input logic [2:0] af,
                         input logic [2:0] ae, input logic [2:0] lvl,
                         input logic full, input logic empty, input logic awf,
                         input logic are, input logic ovf, input logic udf,
                         input logic [7:0] fw, input logic [7:0] rg);
    vec_t v;
    v.w = w; v.wd = wd; v.r = r; v.fl = fl; v.ce = ce; v.af = af; v.ae = ae;
    v.lvl = lvl; v.full = full; v.empty = empty; v.awf = awf; v.are = are;
    v.ovf = ovf; v.udf = udf; v.fw = fw; v.rg = rg;
    vecs.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    flush = 1'b0; clear_err = 1'b0; winc = 1'b0; rinc = 1'b0; wdata = '0;
  endtask

  task automatic apply_vec(input int i, input vec_t v);
    winc = v.w; wdata = v.wd; rinc = v.r; flush = v.fl; clear_err = v.ce;
    af_thresh = v.af; ae_thresh = v.ae;
    @(negedge clk);
    check($sformatf("v%0d level", i),     level,     v.lvl);
    check($sformatf("v%0d level_r", i),   level_r,   v.lvl);
    check($sformatf("v%0d wfull", i),     wfull,     v.full);
    check($sformatf("v%0d rempty", i),    rempty,    v.empty);
    check($sformatf("v%0d awfull", i),    awfull,    v.awf);
    check($sformatf("v%0d arempty", i),   arempty,   v.are);
    check($sformatf("v%0d overflow", i),  overflow,  v.ovf);
    check($sformatf("v%0d underflow", i), underflow, v.udf);
    if (!v.empty) check($sformatf("v%0d rdata_fwft", i), rdata, v.fw);
    check($sformatf("v%0d rdata_reg", i), rdata_r, v.rg);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [DSIZE-1:0] d;

    //        w  wd     r  fl ce af ae  lvl fu em awf are ovf udf fw     rg
    // fill and overflow
    add_vec(1, 8'h11, 0, 0, 0, 3, 1,  1, 0, 0, 0, 1, 0, 0, 8'h11, 8'h00);
    add_vec(1, 8'h22, 0, 0, 0, 3, 1,  2, 0, 0, 0, 0, 0, 0, 8'h11, 8'h00);
    add_vec(1, 8'h33, 0, 0, 0, 3, 1,  3, 0, 0, 1, 0, 0, 0, 8'h11, 8'h00);
    add_vec(1, 8'h44, 0, 0, 0, 3, 1,  4, 1, 0, 1, 0, 0, 0, 8'h11, 8'h00);
    add_vec(1, 8'h55, 0, 0, 0, 3, 1,  4, 1, 0, 1, 0, 1, 0, 8'h11, 8'h00);
    add_vec(0, 8'h00, 0, 0, 1, 3, 1,  4, 1, 0, 1, 0, 0, 0, 8'h11, 8'h00);
    // drain and underflow
    add_vec(0, 8'h00, 1, 0, 0, 3, 1,  3, 0, 0, 1, 0, 0, 0, 8'h22, 8'h11);
    add_vec(0, 8'h00, 1, 0, 0, 3, 1,  2, 0, 0, 0, 0, 0, 0, 8'h33, 8'h22);
    add_vec(0, 8'h00, 1, 0, 0, 3, 1,  1, 0, 0, 0, 1, 0, 0, 8'h44, 8'h33);
    add_vec(0, 8'h00, 1, 0, 0, 3, 1,  0, 0, 1, 0, 1, 0, 0, 8'h00, 8'h44);
    add_vec(0, 8'h00, 1, 0, 0, 3, 1,  0, 0, 1, 0, 1, 0, 1, 8'h00, 8'h44);
    add_vec(0, 8'h00, 0, 0, 1, 3, 1,  0, 0, 1, 0, 1, 0, 0, 8'h00, 8'h44);
    // simultaneous read/write at level 2 across pointer wrap
    add_vec(1, 8'hA0, 0, 0, 0, 3, 1,  1, 0, 0, 0, 1, 0, 0, 8'hA0, 8'h44);
    add_vec(1, 8'hA1, 0, 0, 0, 3, 1,  2, 0, 0, 0, 0, 0, 0, 8'hA0, 8'h44);
    for (int k = 0; k < 10; k++)
      add_vec(1, 8'(8'hA2 + k), 1, 0, 0, 3, 1, 2, 0, 0, 0, 0, 0, 0,
              8'(8'hA1 + k), 8'(8'hA0 + k));
    add_vec(1, 8'hAC, 0, 0, 0, 3, 1,  3, 0, 0, 1, 0, 0, 0, 8'hAA, 8'hA9);
    add_vec(1, 8'hAD, 0, 0, 0, 3, 1,  4, 1, 0, 1, 0, 0, 0, 8'hAA, 8'hA9);
    // write+read while full: only the read goes through
    add_vec(1, 8'hAE, 1, 0, 0, 3, 1,  3, 0, 0, 1, 0, 1, 0, 8'hAB, 8'hAA);
    // flush with winc/rinc at level 3, then flush with rinc while empty
    add_vec(1, 8'hEE, 1, 1, 0, 3, 1,  0, 0, 1, 0, 1, 1, 0, 8'h00, 8'hAA);
    add_vec(0, 8'h00, 1, 1, 0, 3, 1,  0, 0, 1, 0, 1, 1, 0, 8'h00, 8'hAA);
    add_vec(0, 8'h00, 0, 0, 1, 3, 1,  0, 0, 1, 0, 1, 0, 0, 8'h00, 8'hAA);
    // read latency per mode
    add_vec(1, 8'hA5, 0, 0, 0, 3, 1,  1, 0, 0, 0, 1, 0, 0, 8'hA5, 8'hAA);
    add_vec(0, 8'h00, 0, 0, 0, 3, 1,  1, 0, 0, 0, 1, 0, 0, 8'hA5, 8'hAA);
    add_vec(0, 8'h00, 1, 0, 0, 3, 1,  0, 0, 1, 0, 1, 0, 0, 8'h00, 8'hA5);
    add_vec(0, 8'h00, 0, 0, 0, 3, 1,  0, 0, 1, 0, 1, 0, 0, 8'h00, 8'hA5);
    // thresholds while filling 0 -> 4
    add_vec(1, 8'h01, 0, 0, 0, 3, 1,  1, 0, 0, 0, 1, 0, 0, 8'h01, 8'hA5);
    add_vec(1, 8'h02, 0, 0, 0, 3, 1,  2, 0, 0, 0, 0, 0, 0, 8'h01, 8'hA5);
    add_vec(1, 8'h03, 0, 0, 0, 3, 1,  3, 0, 0, 1, 0, 0, 0, 8'h01, 8'hA5);
    add_vec(1, 8'h04, 0, 0, 0, 3, 1,  4, 1, 0, 1, 0, 0, 0, 8'h01, 8'hA5);
    // clear_err beats a same-cycle overflow set
    add_vec(1, 8'h09, 0, 0, 1, 3, 1,  4, 1, 0, 1, 0, 0, 0, 8'h01, 8'hA5);
    // af above DEPTH never asserts; ae at DEPTH always asserts
    add_vec(0, 8'h00, 0, 0, 0, 5, 4,  4, 1, 0, 0, 1, 0, 0, 8'h01, 8'hA5);
    add_vec(0, 8'h00, 0, 0, 0, 4, 3,  4, 1, 0, 1, 0, 0, 0, 8'h01, 8'hA5);

    // reset state
    drive_idle();
    rst = 1'b1; af_thresh = 3'd3; ae_thresh = 3'd1;
    repeat (2) @(negedge clk);
    check("rst level",     level,     3'd0);
    check("rst rempty",    rempty,    1'b1);
    check("rst arempty",   arempty,   1'b1);
    check("rst wfull",     wfull,     1'b0);
    check("rst awfull",    awfull,    1'b0);
    check("rst overflow",  overflow,  1'b0);
    check("rst underflow", underflow, 1'b0);
    check("rst rdata_reg", rdata_r,   8'h00);
    af_thresh = 3'd0;
    #1 check("rst awfull af0", awfull, 1'b1);
    af_thresh = 3'd3;
    rst = 1'b0;

    foreach (vecs[i]) apply_vec(i, vecs[i]);
    drive_idle();

    // thresholds act without waiting for an edge (level is 4 here)
    af_thresh = 3'd5;
    #1 check("thr af5 immediate", awfull, 1'b0);
    ae_thresh = 3'd4;
    #1 check("thr ae4 immediate", arempty, 1'b1);

    // reset mid-run with a full FIFO
    rst = 1'b1; af_thresh = 3'd0;
    @(negedge clk);
    check("rst2 level",     level,   3'd0);
    check("rst2 rempty",    rempty,  1'b1);
    check("rst2 awfull",    awfull,  1'b1);
    check("rst2 rdata_reg", rdata_r, 8'h00);
    rst = 1'b0; af_thresh = 3'd3; ae_thresh = 3'd1;

    // scoreboard pass: random words through both read modes
    for (int k = 0; k < 4; k++) begin
      d = DSIZE'($urandom_range(0, 255));
      winc = 1'b1; wdata = d;
      exp_q.push_back(d);
      @(negedge clk);
    end
    winc = 1'b0;
    check("sb full", wfull, 1'b1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("sb%0d rdata_fwft", k), rdata, exp_q[0]);
      rinc = 1'b1;
      @(negedge clk);
      rinc = 1'b0;
      d = exp_q.pop_front();
      check($sformatf("sb%0d rdata_reg", k), rdata_r, d);
    end
    check("sb empty", rempty, 1'b1);
    check("sb level", level, 3'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
